// File: rtl/tpg_pkg.sv
// Shared definitions for the video test-pattern generator:
// pattern mode codes, the colour-bar table and elaboration-time helpers.
package tpg_pkg;

    localparam logic [1:0] MODE_BARS    = 2'd0;
    localparam logic [1:0] MODE_RAMP    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_SOLID   = 2'd3;

    // {R,G,B} on/off bits, entry 0 is the left-most bar.
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

    function automatic int bar_width(int h_active, int num_bars);
        return h_active / num_bars;
    endfunction

    // Fixed-point (8 fractional bits) grey step per pixel.
    function automatic int ramp_inc(int h_active, int color_w);
        return (1 << (color_w + 8)) / h_active;
    endfunction

    function automatic logic [2:0] bar_rgb(logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/tpg_if.sv
// Video bundle between timing generator/register block and the
// pattern generator: coordinates + controls in, RGB + data-enable out.
interface tpg_if #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8
);
    logic                   video_active;
    logic [COORD_W-1:0]     pixel_x;
    logic [COORD_W-1:0]     pixel_y;
    logic                   enable;
    logic [1:0]             mode;
    logic [3*COLOR_W-1:0]   solid_rgb;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   de_out;

    modport master (
        output video_active, pixel_x, pixel_y, enable, mode, solid_rgb,
        input  red, green, blue, de_out
    );

    modport slave (
        input  video_active, pixel_x, pixel_y, enable, mode, solid_rgb,
        output red, green, blue, de_out
    );
endinterface

// File: rtl/tpg_bar_indexer.sv
// Colour-bar position tracker: counts active pixels along a line and
// reports which bar the current pixel belongs to.
// Ports: clk, rst (async, active-high), active_i (pixel qualifier),
//        x_zero_i (pixel_x==0, restarts the line), bar_idx_o (current bar).
module tpg_bar_indexer
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int NUM_BARS = 8,
    parameter int COORD_W  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active_i,
    input  logic       x_zero_i,
    output logic [2:0] bar_idx_o
);

    localparam int BAR_W = bar_width(H_ACTIVE, NUM_BARS);
    localparam logic [COORD_W-1:0] CNT_LAST = COORD_W'(BAR_W - 1);
    localparam logic [2:0]         IDX_LAST = 3'(NUM_BARS - 1);

    logic [COORD_W-1:0] cnt_q, cnt_d, cnt_cur;
    logic [2:0]         idx_q, idx_d, idx_cur;

    // The x==0 pixel sees cleared counters so every line starts in bar 0.
    always_comb begin
        cnt_cur = x_zero_i ? '0 : cnt_q;
        idx_cur = x_zero_i ? '0 : idx_q;
        cnt_d   = cnt_cur;
        idx_d   = idx_cur;
        if (active_i) begin
            // The last bar never advances, so it absorbs the remainder.
            if (cnt_cur == CNT_LAST && idx_cur < IDX_LAST) begin
                idx_d = idx_cur + 3'd1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign bar_idx_o = idx_cur;

endmodule

// File: rtl/test_pattern_generator.sv
// Video test-pattern source (bars, grey ramp, scrolling checker, solid)
// with a fixed 2-cycle pipeline. Ports: clk, rst (async, active-high),
// vid (tpg_if.slave: timing/controls in, red/green/blue/de_out out).
module test_pattern_generator
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COORD_W    = 10,
    parameter int COLOR_W    = 8,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic clk,
    input  logic rst,
    tpg_if.slave vid
);

    localparam int RGB_W = 3 * COLOR_W;
    localparam int ACC_W = COLOR_W + 9;
    localparam logic [ACC_W-1:0] RAMP_STEP =
        ACC_W'(ramp_inc(H_ACTIVE, COLOR_W));
    localparam logic [COORD_W:0] H_LIM = (COORD_W + 1)'(H_ACTIVE);
    localparam logic [COORD_W:0] V_LIM = (COORD_W + 1)'(V_ACTIVE);

    logic               x_zero, frame_start, in_area;
    logic [1:0]         mode_q, mode_d;
    logic [RGB_W-1:0]   solid_q, solid_d;
    logic [COORD_W-1:0] frame_cnt_q, scroll_q, scroll_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_cur;
    logic [COLOR_W-1:0] grey;
    logic [COORD_W-1:0] chk_sum;
    logic               chk_white;
    logic [2:0]         bar_idx, bar_bits;
    logic [RGB_W-1:0]   bar_col, pix_col;

    logic               de1_q, en1_q, de2_q;
    logic [RGB_W-1:0]   rgb1_q, rgb2_q;

    tpg_bar_indexer #(
        .H_ACTIVE (H_ACTIVE),
        .NUM_BARS (NUM_BARS),
        .COORD_W  (COORD_W)
    ) u_bar_indexer (
        .clk       (clk),
        .rst       (rst),
        .active_i  (vid.video_active),
        .x_zero_i  (x_zero),
        .bar_idx_o (bar_idx)
    );

    always_comb begin
        x_zero      = (vid.pixel_x == '0);
        frame_start = vid.video_active && x_zero && (vid.pixel_y == '0);
        in_area     = ({1'b0, vid.pixel_x} < H_LIM) &&
                      ({1'b0, vid.pixel_y} < V_LIM);

        // Shadow values; the frame-start pixel already uses the new ones.
        mode_d   = frame_start ? vid.mode      : mode_q;
        solid_d  = frame_start ? vid.solid_rgb : solid_q;
        scroll_d = frame_start ? frame_cnt_q   : scroll_q;

        // Ramp accumulator: extra top bit flags overflow -> saturate.
        acc_cur = x_zero ? '0 : acc_q;
        grey    = acc_cur[ACC_W-1] ? '1 : acc_cur[COLOR_W+7:8];
        acc_d   = acc_cur;
        if (vid.video_active && !acc_cur[ACC_W-1])
            acc_d = acc_cur + RAMP_STEP;

        // Even cells are white so the origin cell is white.
        chk_sum   = vid.pixel_x + scroll_d;
        chk_white = ~(chk_sum[CHECK_LOG2] ^ vid.pixel_y[CHECK_LOG2]);

        bar_bits = bar_rgb(bar_idx);
        bar_col  = {{COLOR_W{bar_bits[2]}},
                    {COLOR_W{bar_bits[1]}},
                    {COLOR_W{bar_bits[0]}}};

        pix_col = '0;
        unique case (mode_d)
            MODE_BARS:    pix_col = bar_col;
            MODE_RAMP:    pix_col = {3{grey}};
            MODE_CHECKER: pix_col = {RGB_W{chk_white}};
            MODE_SOLID:   pix_col = solid_d;
        endcase
        // Coordinates outside the configured raster render black.
        if (!in_area)
            pix_col = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_BARS;
            solid_q     <= '0;
            scroll_q    <= '0;
            frame_cnt_q <= '0;
            acc_q       <= '0;
            de1_q       <= 1'b0;
            en1_q       <= 1'b0;
            rgb1_q      <= '0;
            de2_q       <= 1'b0;
            rgb2_q      <= '0;
        end else begin
            mode_q   <= mode_d;
            solid_q  <= solid_d;
            scroll_q <= scroll_d;
            if (frame_start)
                frame_cnt_q <= frame_cnt_q + 1'b1;
            acc_q  <= acc_d;
            de1_q  <= vid.video_active;
            en1_q  <= vid.enable;
            rgb1_q <= pix_col;
            de2_q  <= de1_q;
            rgb2_q <= (de1_q && en1_q) ? rgb1_q : '0;
        end
    end

    assign vid.red    = rgb2_q[3*COLOR_W-1:2*COLOR_W];
    assign vid.green  = rgb2_q[2*COLOR_W-1:COLOR_W];
    assign vid.blue   = rgb2_q[COLOR_W-1:0];
    assign vid.de_out = de2_q;

endmodule
